// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_pkg
//  Description : Shared definitions for the parallel-in serial-out serializer:
//                FSM state encoding, default word width and counter sizing.
//  Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

   // Default parallel word width
   localparam int unsigned c_default_width = 8;

   // Serializer states: IDLE holds no word, SHIFT has bits left to emit
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } piso_state_e;

   // Bit-index counter width for a given word width (at least one bit)
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/piso_bit_counter.sv
`default_nettype none
// ============================================================================
//  Module      : piso_bit_counter
//  Description : Bit-index counter for the serializer. Clears to zero,
//                increments on enable and saturates at WIDTH-1.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH = c_default_width
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         clear,
   input  logic                         en,
   output logic [cnt_width(WIDTH)-1:0]  count,
   output logic                         at_last
);

   localparam int unsigned        c_cnt_w = cnt_width(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

   logic [c_cnt_w-1:0] count_q;
   logic [c_cnt_w-1:0] count_d;

   // Next count: clear wins, otherwise step while below the final index
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (en && (count_q != c_last)) begin
         count_d = count_q + c_cnt_w'(1);
      end
   end

   // Count register with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count   = count_q;
   assign at_last = (count_q == c_last);

endmodule
`default_nettype wire

// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : piso_serializer
//  Description : Parallel-in serial-out serializer with valid/ready load,
//                shift enable stall, last-bit flag and back-to-back words.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer
   import piso_pkg::*;
#(
   parameter int unsigned WIDTH     = c_default_width,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] din,
   input  logic             shift_en,
   output logic             sout,
   output logic             sout_valid,
   output logic             last,
   output logic             busy
);

   localparam int unsigned        c_cnt_w    = cnt_width(WIDTH);
   localparam logic [c_cnt_w-1:0] c_last_idx = c_cnt_w'(WIDTH - 1);

   piso_state_e        state_q;
   piso_state_e        state_d;
   logic [WIDTH-1:0]   word_q;
   logic [WIDTH-1:0]   word_d;
   logic [c_cnt_w-1:0] bit_idx;
   logic [c_cnt_w-1:0] sel_idx;
   logic               at_last;
   logic               in_shift;
   logic               final_bit;
   logic               accept;
   logic               advance;

   // The held word stays static; the bit index picks the bit on sout
   generate
      if (MSB_FIRST) begin : g_msb_first
         assign sel_idx = c_last_idx - bit_idx;
      end else begin : g_lsb_first
         assign sel_idx = bit_idx;
      end
   endgenerate

   // Handshake and next-state decode; a word arriving on the final-bit edge
   // is taken directly so consecutive frames have no idle gap
   always_comb begin
      in_shift   = (state_q == ST_SHIFT);
      final_bit  = in_shift && at_last && shift_en;
      load_ready = !in_shift || final_bit;
      accept     = load_valid && load_ready;
      advance    = in_shift && shift_en && !at_last;
      state_d    = state_q;
      word_d     = word_q;
      if (accept) begin
         state_d = ST_SHIFT;
         word_d  = din;
      end else if (final_bit) begin
         state_d = ST_IDLE;
         word_d  = '0;
      end
   end

   // FSM state and held word; reset discards any partial frame
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         word_q  <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
      end
   end

   piso_bit_counter #(
      .WIDTH (WIDTH)
   ) u_bit_counter (
      .clk     (clk),
      .rst     (rst),
      .clear   (accept || final_bit),
      .en      (advance),
      .count   (bit_idx),
      .at_last (at_last)
   );

   assign sout       = in_shift && word_q[sel_idx];
   assign sout_valid = in_shift;
   assign busy       = in_shift;
   assign last       = in_shift && at_last;

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_serializer
//  Description : Self-checking bench for piso_serializer. Three instances
//                (4-bit LSB-first, 4-bit MSB-first, 8-bit MSB-first) are
//                compared each cycle against a pending-bit list model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

   logic       clk;
   logic       rst;
   logic       lv   [3];
   logic       se   [3];
   logic [7:0] din8 [3];
   logic       lr   [3];
   logic       so   [3];
   logic       sv   [3];
   logic       la   [3];
   logic       bz   [3];

   // Model: per instance, list of bits still to appear on sout (front = bit 0)
   int          wid   [3];
   bit          msbf  [3];
   logic [15:0] mbits [3];
   int          mcnt  [3];

   // Observed serial streams (oldest bit at the high end)
   logic [31:0] cap  [3];
   int          ncap [3];

   int errors;
   int checks;

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) u_w4_lsb (
      .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(lr[0]), .din(din8[0][3:0]),
      .shift_en(se[0]), .sout(so[0]), .sout_valid(sv[0]), .last(la[0]), .busy(bz[0]));

   piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b1)) u_w4_msb (
      .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(lr[1]), .din(din8[1][3:0]),
      .shift_en(se[1]), .sout(so[1]), .sout_valid(sv[1]), .last(la[1]), .busy(bz[1]));

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_w8_msb (
      .clk(clk), .rst(rst), .load_valid(lv[2]), .load_ready(lr[2]), .din(din8[2]),
      .shift_en(se[2]), .sout(so[2]), .sout_valid(sv[2]), .last(la[2]), .busy(bz[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, idx, obs, exp);
      end
   endtask

   task automatic clear_cap(input int i);
      cap[i]  = '0;
      ncap[i] = 0;
   endtask

   task automatic idle_inputs();
      for (int i = 0; i < 3; i++) begin
         lv[i]   = 1'b0;
         se[i]   = 1'b1;
         din8[i] = '0;
      end
   endtask

   task automatic check_outputs();
      for (int i = 0; i < 3; i++) begin
         chk("sout",       i, {31'b0, so[i]}, (mcnt[i] > 0) ? {31'b0, mbits[i][0]} : 32'd0);
         chk("sout_valid", i, {31'b0, sv[i]}, {31'b0, (mcnt[i] > 0)});
         chk("last",       i, {31'b0, la[i]}, {31'b0, (mcnt[i] == 1)});
         chk("busy",       i, {31'b0, bz[i]}, {31'b0, (mcnt[i] > 0)});
      end
   endtask

   // One clock: check ready with current inputs, advance model, clock, check outputs
   task automatic tick();
      bit acc [3];
      bit exp_ready;
      int pos;
      #1;
      for (int i = 0; i < 3; i++) begin
         exp_ready = (mcnt[i] == 0) || ((mcnt[i] == 1) && se[i]);
         chk("load_ready", i, {31'b0, lr[i]}, {31'b0, exp_ready});
         acc[i] = lv[i] && exp_ready;
      end
      for (int i = 0; i < 3; i++) begin
         if (se[i] && (mcnt[i] > 0)) begin
            mbits[i] = mbits[i] >> 1;
            mcnt[i]  = mcnt[i] - 1;
         end
         if (acc[i]) begin
            for (int j = 0; j < wid[i]; j++) begin
               pos = msbf[i] ? (wid[i] - 1 - j) : j;
               mbits[i][mcnt[i] + j] = din8[i][pos];
            end
            mcnt[i] = mcnt[i] + wid[i];
         end
      end
      @(posedge clk);
      #1;
      check_outputs();
      for (int i = 0; i < 3; i++) begin
         if (sv[i]) begin
            cap[i]  = {cap[i][30:0], so[i]};
            ncap[i] = ncap[i] + 1;
         end
      end
   endtask

   initial begin
      logic [7:0] w;
      errors  = 0;
      checks  = 0;
      wid[0]  = 4; msbf[0] = 1'b0;
      wid[1]  = 4; msbf[1] = 1'b1;
      wid[2]  = 8; msbf[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mbits[i] = '0;
         mcnt[i]  = 0;
         clear_cap(i);
      end
      idle_inputs();
      rst = 1'b0;

      // Reset state
      #1 rst = 1'b1;
      #2;
      check_outputs();
      for (int i = 0; i < 3; i++) chk("reset_ready", i, {31'b0, lr[i]}, 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // 4-bit LSB-first, 0011 -> 1,1,0,0 then idle
      clear_cap(0);
      lv[0] = 1'b1; din8[0] = 8'h03;
      tick();
      lv[0] = 1'b0;
      repeat (4) tick();
      chk("lsb_stream", 0, cap[0], 32'hC);
      chk("lsb_nbits",  0, ncap[0], 32'd4);

      // 4-bit MSB-first, 0111 then 1100 offered during last -> no gap
      clear_cap(1);
      lv[1] = 1'b1; din8[1] = 8'h07;
      tick();
      lv[1] = 1'b0;
      repeat (3) tick();
      lv[1] = 1'b1; din8[1] = 8'h0C;
      tick();
      lv[1] = 1'b0;
      repeat (4) tick();
      chk("b2b_stream", 1, cap[1], 32'h7C);
      chk("b2b_nbits",  1, ncap[1], 32'd8);

      // 8-bit A5 with a three-cycle stall after bit 2
      clear_cap(2);
      lv[2] = 1'b1; din8[2] = 8'hA5;
      tick();
      lv[2] = 1'b0;
      repeat (2) tick();
      se[2] = 1'b0;
      repeat (3) tick();
      se[2] = 1'b1;
      repeat (6) tick();
      chk("stall_stream", 2, cap[2], 32'h5E5);
      chk("stall_nbits",  2, ncap[2], 32'd11);

      // Reset mid-frame on FF, then 00 accepted on the first edge after release
      lv[2] = 1'b1; din8[2] = 8'hFF;
      tick();
      lv[2] = 1'b0;
      repeat (2) tick();
      #2 rst = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) mcnt[i] = 0;
      check_outputs();
      for (int i = 0; i < 3; i++) chk("midreset_ready", i, {31'b0, lr[i]}, 32'd1);
      #3 rst = 1'b0;
      clear_cap(2);
      lv[2] = 1'b1; din8[2] = 8'h00;
      tick();
      lv[2] = 1'b0;
      repeat (8) tick();
      chk("postreset_stream", 2, cap[2], 32'h0);
      chk("postreset_nbits",  2, ncap[2], 32'd8);

      // Changing din with load_valid held mid-frame is ignored
      w = 8'($urandom);
      clear_cap(1);
      lv[1] = 1'b1; din8[1] = w;
      tick();
      repeat (3) begin
         din8[1] = 8'($urandom);
         tick();
      end
      lv[1] = 1'b0;
      tick();
      chk("hold_stream", 1, cap[1], {28'b0, w[3:0]});
      chk("hold_nbits",  1, ncap[1], 32'd4);

      // Randomized traffic on all instances
      for (int n = 0; n < 250; n++) begin
         for (int i = 0; i < 3; i++) begin
            lv[i]   = 1'($urandom_range(0, 1));
            se[i]   = ($urandom_range(0, 3) != 0);
            din8[i] = 8'($urandom);
         end
         tick();
      end
      idle_inputs();
      repeat (12) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, giving the parallel word width in bits (legal range 2..64).
REQ-002 SHALL provide parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 is shifted out first; 0 = bit 0 is shifted out first.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port load_valid  input  1  a parallel word is offered on din.
REQ-006 SHALL have port load_ready  output  1  the block can accept a word this cycle.
REQ-007 SHALL have port din  input  WIDTH  the parallel word to serialize.
REQ-008 SHALL have port shift_en  input  1  advance enable; 0 stalls serialization.
REQ-009 SHALL have port sout  output  1  the serial data bit.
REQ-010 SHALL have port sout_valid  output  1  sout carries a valid bit this cycle.
REQ-011 SHALL have port last  output  1  sout is the final bit of the current word.
REQ-012 SHALL have port busy  output  1  a word is being serialized.

Function
REQ-013 SHALL implement a two-state FSM: IDLE (no word held) and SHIFT (word held, bits remaining).
REQ-014 SHALL accept a word on a rising edge where load_valid=1 and load_ready=1, capturing din and entering SHIFT with bit index 0.
REQ-015 SHALL drive load_ready=1 in IDLE, and in SHIFT only when last=1 and shift_en=1; otherwise 0.
REQ-016 SHALL present the first bit on sout, with sout_valid=1, in the cycle after acceptance (latency 1 cycle).
REQ-017 SHALL, in SHIFT, drive sout_valid=1 and busy=1, present bit index k (MSB or LSB order per MSB_FIRST), and advance k by one on each edge where shift_en=1.
REQ-018 SHALL hold sout, k, and last unchanged on edges where shift_en=0.
REQ-019 SHALL assert last exactly when k = WIDTH-1 in SHIFT.
REQ-020 SHALL return to IDLE after the final bit is consumed (last=1, shift_en=1) when no new word is accepted on that edge.
REQ-021 SHALL, when a new word is accepted on the same edge the final bit is consumed, remain in SHIFT with k=0 and the new word's first bit on sout the next cycle (no bubble).
REQ-022 SHALL drive sout=0, sout_valid=0, last=0, busy=0 in IDLE.
REQ-023 SHALL ignore din and load_valid whenever load_ready=0; the held word is never overwritten mid-frame.
REQ-024 SHALL size the bit counter to $clog2(WIDTH) bits and never let it exceed WIDTH-1.

Reset
REQ-025 SHALL on rst=1, immediately and regardless of clk, enter IDLE, clear the shift register and counter, and force sout=0, sout_valid=0, last=0, busy=0, load_ready=1.
REQ-026 SHALL discard any partially serialized word on reset mid-frame; no remaining bits are emitted after reset deasserts.
REQ-027 SHALL accept a word on the first rising edge after rst deasserts if load_valid=1.

Structure
REQ-028 SHALL place the FSM state encoding (IDLE, SHIFT) in shared package piso_pkg.
REQ-029 SHALL place the default WIDTH constant in shared package piso_pkg.
REQ-030 SHALL implement the bit-index counter as sub-module piso_bit_counter, with parameter WIDTH and ports clk, rst, clear, en, count, at_last.

Verification
REQ-031 SHALL verify: WIDTH=4, MSB_FIRST=0, shift_en=1, load 4'b0011 -> sout 1,1,0,0 on cycles 1..4 after acceptance, last on cycle 4 only, then busy=0.
REQ-032 SHALL verify: WIDTH=4, MSB_FIRST=1, load 4'b0111 -> sout 0,1,1,1; then load_valid held with 4'b1100 during last -> sout 1,1,0,0 immediately following with no idle cycle.
REQ-033 SHALL verify: WIDTH=8, load 8'hA5, shift_en=0 for 3 cycles after bit 2 -> sout holds bit 2 for 4 cycles, total frame 11 cycles, bit order unchanged.
REQ-034 SHALL verify: load 8'hFF, assert rst after 3 bits -> outputs 0 and load_ready=1 immediately; after release, load 8'h00 -> eight 0 bits, no 1 emitted.
REQ-035 SHALL verify: load_valid=1 with din changing every cycle mid-frame -> load_ready=0 and the serialized word equals the originally captured value.
